// File: rtl/nx_ram_wq_pkg.sv
// nx_ram_wq_pkg: shared constants and lane helpers for nx_ram_2rw_wq.
//   STATS_W    : width of the refused-write statistics counter
//   MAX_W      : widest data word the lane helpers handle
//   lane_mask  : expands a per-lane enable vector into a per-bit mask
//   lane_merge : overlays the masked bits of an update onto a base word
package nx_ram_wq_pkg;

    localparam int STATS_W = 32;
    localparam int MAX_W   = 1024;
    localparam int MAX_AW  = $clog2(MAX_W);

    // width and bwewidth are elaboration constants at every call site, so
    // this reduces to plain wiring.
    function automatic logic [MAX_W-1:0] lane_mask(input logic [MAX_W-1:0] lanes,
                                                   input int width, input int bwewidth);
        logic [MAX_W-1:0] m;
        int               lw;
        m  = '0;
        lw = width / bwewidth;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) m[MAX_AW'(i)] = lanes[MAX_AW'(i / lw)];
        end
        return m;
    endfunction

    function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0] base,
                                                    input logic [MAX_W-1:0] upd,
                                                    input logic [MAX_W-1:0] mask);
        return (base & ~mask) | (upd & mask);
    endfunction

endpackage

// File: rtl/nx_ram_wq_fifo.sv
// nx_ram_wq_fifo: pending port-A write queue for nx_ram_2rw_wq.
// Slot 0 is always the head (oldest); a pop shifts every slot down one, so
// slot index equals age order for the forwarding lookups.
//   push/push_*   : enqueue {addr, data, lanes} at the tail
//   pop           : drop the head
//   clr_*         : clear lanes of every pending entry at clr_addr (B write)
//   look_a/look_b : lookup addresses; match_a/match_b flag live slots hitting them
//   level         : occupied slots; head_addr/slot_data/slot_lanes expose contents
module nx_ram_wq_fifo
    import nx_ram_wq_pkg::*;
#(
    parameter int SLOTS    = 4,
    parameter int ADDR_W   = 8,
    parameter int WIDTH    = 64,
    parameter int BWEWIDTH = 64,
    parameter int CNT_W    = $clog2(SLOTS) + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic [ADDR_W-1:0]                  push_addr,
    input  logic [WIDTH-1:0]                   push_data,
    input  logic [BWEWIDTH-1:0]                push_lanes,
    input  logic                               pop,
    input  logic                               clr_en,
    input  logic [ADDR_W-1:0]                  clr_addr,
    input  logic [BWEWIDTH-1:0]                clr_lanes,
    input  logic [ADDR_W-1:0]                  look_a,
    input  logic [ADDR_W-1:0]                  look_b,
    output logic [CNT_W-1:0]                   level,
    output logic [ADDR_W-1:0]                  head_addr,
    output logic [SLOTS-1:0]                   match_a,
    output logic [SLOTS-1:0]                   match_b,
    output logic [SLOTS-1:0][WIDTH-1:0]        slot_data,
    output logic [SLOTS-1:0][BWEWIDTH-1:0]     slot_lanes
);

    logic [SLOTS-1:0][ADDR_W-1:0]   addr_q,  addr_d;
    logic [SLOTS-1:0][WIDTH-1:0]    data_q,  data_d;
    logic [SLOTS-1:0][BWEWIDTH-1:0] lanes_q, lanes_d;
    logic [CNT_W-1:0]               cnt_q,   cnt_d;

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        lanes_d = lanes_q;
        cnt_d   = cnt_q;
        // A B write supersedes older queued data in the lanes it covers.
        if (clr_en) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (CNT_W'(i) < cnt_q && addr_q[i] == clr_addr)
                    lanes_d[i] = lanes_q[i] & ~clr_lanes;
            end
        end
        if (pop) begin
            for (int i = 0; i < SLOTS - 1; i++) begin
                addr_d[i]  = addr_d[i+1];
                data_d[i]  = data_d[i+1];
                lanes_d[i] = lanes_d[i+1];
            end
            cnt_d = cnt_q - CNT_W'(1);
        end
        // Tail position is taken after any pop in the same cycle.
        if (push) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (CNT_W'(i) == cnt_d) begin
                    addr_d[i]  = push_addr;
                    data_d[i]  = push_data;
                    lanes_d[i] = push_lanes;
                end
            end
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int i = 0; i < SLOTS; i++) begin
            match_a[i] = (CNT_W'(i) < cnt_q) && (addr_q[i] == look_a);
            match_b[i] = (CNT_W'(i) < cnt_q) && (addr_q[i] == look_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Slot payload needs no reset: only slots below cnt_q are ever used.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        data_q  <= data_d;
        lanes_q <= lanes_d;
    end

    assign level      = cnt_q;
    assign head_addr  = addr_q[0];
    assign slot_data  = data_q;
    assign slot_lanes = lanes_q;

endmodule

// File: rtl/nx_ram_2rw_wq.sv
// nx_ram_2rw_wq: two read/write port RAM on a single physical write port.
// Port B writes commit at once; port A writes are queued in nx_ram_wq_fifo
// and drain into the array in cycles without a B write. Reads on both ports
// see queued (and, with WRITETHROUGH, same-cycle) writes through per-lane
// forwarding.
//   clk, rst_n                 : clock, async active-low reset
//   csa/wea/adda/dina/bwea     : port A request; rdya = queue has a free slot
//   douta/vlda                 : port A read data / one-cycle valid
//   csb/web/addb/dinb/bweb     : port B request (never refused)
//   doutb/vldb                 : port B read data / one-cycle valid
//   wq_level                   : occupied queue slots
//   stall_cnt/wq_hwm           : refused A writes / queue high-water mark,
//                                live only with NX_RAM_2RW_WQ_STATS_EN defined
module nx_ram_2rw_wq
    import nx_ram_wq_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int BWEWIDTH     = WIDTH,
    parameter int DEPTH        = 256,
    parameter int RD_LATENCY   = 1,
    parameter int WQ_DEPTH     = 4,
    parameter int WRITETHROUGH = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        csa,
    input  logic                        wea,
    input  logic [$clog2(DEPTH)-1:0]    adda,
    input  logic [WIDTH-1:0]            dina,
    input  logic [BWEWIDTH-1:0]         bwea,
    output logic                        rdya,
    output logic [WIDTH-1:0]            douta,
    output logic                        vlda,
    input  logic                        csb,
    input  logic                        web,
    input  logic [$clog2(DEPTH)-1:0]    addb,
    input  logic [WIDTH-1:0]            dinb,
    input  logic [BWEWIDTH-1:0]         bweb,
    output logic [WIDTH-1:0]            doutb,
    output logic                        vldb,
    output logic [$clog2(WQ_DEPTH):0]   wq_level,
    output logic [STATS_W-1:0]          stall_cnt,
    output logic [$clog2(WQ_DEPTH):0]   wq_hwm
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WQ_DEPTH) + 1;
    localparam int LW = WIDTH / BWEWIDTH;
    localparam int RL = RD_LATENCY;

    function automatic logic [WIDTH-1:0] fwd(input logic [WIDTH-1:0]    base,
                                             input logic [WIDTH-1:0]    upd,
                                             input logic [BWEWIDTH-1:0] lanes);
        logic [MAX_W-1:0] m;
        logic [MAX_W-1:0] r;
        m = lane_mask(MAX_W'(lanes), WIDTH, BWEWIDTH);
        r = lane_merge(MAX_W'(base), MAX_W'(upd), m);
        return r[WIDTH-1:0];
    endfunction

    logic a_wr, a_drop, a_rd, b_wr, b_rd, drain;
    logic [CW-1:0]                       level;
    logic [AW-1:0]                       head_addr;
    logic [WQ_DEPTH-1:0]                 match_a, match_b;
    logic [WQ_DEPTH-1:0][WIDTH-1:0]      slot_data;
    logic [WQ_DEPTH-1:0][BWEWIDTH-1:0]   slot_lanes;

    // Ready depends on stored level only; a drain this cycle does not help.
    assign rdya   = level < CW'(WQ_DEPTH);
    assign a_wr   = csa & wea & rdya;
    assign a_drop = csa & wea & ~rdya;
    assign a_rd   = csa & ~wea;
    assign b_wr   = csb & web;
    assign b_rd   = csb & ~web;
    assign drain  = (level != '0) & ~b_wr;
    assign wq_level = level;

    nx_ram_wq_fifo #(
        .SLOTS    (WQ_DEPTH),
        .ADDR_W   (AW),
        .WIDTH    (WIDTH),
        .BWEWIDTH (BWEWIDTH),
        .CNT_W    (CW)
    ) u_wq (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (a_wr),
        .push_addr  (adda),
        .push_data  (dina),
        .push_lanes (bwea),
        .pop        (drain),
        .clr_en     (b_wr),
        .clr_addr   (addb),
        .clr_lanes  (bweb),
        .look_a     (adda),
        .look_b     (addb),
        .level      (level),
        .head_addr  (head_addr),
        .match_a    (match_a),
        .match_b    (match_b),
        .slot_data  (slot_data),
        .slot_lanes (slot_lanes)
    );

    // Single physical write port: B has priority, the queue head fills gaps.
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [BWEWIDTH-1:0] mem_wlanes;

    always_comb begin
        mem_we     = 1'b0;
        mem_waddr  = head_addr;
        mem_wdata  = slot_data[0];
        mem_wlanes = slot_lanes[0];
        if (b_wr) begin
            mem_we     = 1'b1;
            mem_waddr  = addb;
            mem_wdata  = dinb;
            mem_wlanes = bweb;
        end else if (drain) begin
            // A head fully overwritten by later B writes just pops.
            mem_we = |slot_lanes[0];
        end
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int l = 0; l < BWEWIDTH; l++) begin
                if (mem_wlanes[l]) mem_q[mem_waddr][l*LW +: LW] <= mem_wdata[l*LW +: LW];
            end
        end
    end

    // Coherent read word: array, then queued entries oldest to youngest, then
    // the other port's same-cycle write (a port cannot read and write at once).
    logic [WIDTH-1:0] rdata_a, rdata_b;

    always_comb begin
        rdata_a = mem_q[adda];
        rdata_b = mem_q[addb];
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if (match_a[i]) rdata_a = fwd(rdata_a, slot_data[i], slot_lanes[i]);
            if (match_b[i]) rdata_b = fwd(rdata_b, slot_data[i], slot_lanes[i]);
        end
        if (WRITETHROUGH != 0) begin
            if (b_wr && addb == adda) rdata_a = fwd(rdata_a, dinb, bweb);
            if (a_wr && adda == addb) rdata_b = fwd(rdata_b, dina, bwea);
        end
    end

    // Read pipeline: each stage loads only when a valid read enters it, so
    // the last stage holds the previous result between reads.
    logic [RL-1:0]            vlda_pipe_q, vlda_pipe_d, vldb_pipe_q, vldb_pipe_d;
    logic [RL-1:0][WIDTH-1:0] da_pipe_q, da_pipe_d, db_pipe_q, db_pipe_d;

    always_comb begin
        vlda_pipe_d    = '0;
        vldb_pipe_d    = '0;
        da_pipe_d      = da_pipe_q;
        db_pipe_d      = db_pipe_q;
        vlda_pipe_d[0] = a_rd;
        vldb_pipe_d[0] = b_rd;
        if (a_rd) da_pipe_d[0] = rdata_a;
        if (b_rd) db_pipe_d[0] = rdata_b;
        for (int i = 1; i < RL; i++) begin
            vlda_pipe_d[i] = vlda_pipe_q[i-1];
            vldb_pipe_d[i] = vldb_pipe_q[i-1];
            if (vlda_pipe_q[i-1]) da_pipe_d[i] = da_pipe_q[i-1];
            if (vldb_pipe_q[i-1]) db_pipe_d[i] = db_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vlda_pipe_q <= '0;
            vldb_pipe_q <= '0;
            da_pipe_q   <= '0;
            db_pipe_q   <= '0;
        end else begin
            vlda_pipe_q <= vlda_pipe_d;
            vldb_pipe_q <= vldb_pipe_d;
            da_pipe_q   <= da_pipe_d;
            db_pipe_q   <= db_pipe_d;
        end
    end

    assign vlda  = vlda_pipe_q[RL-1];
    assign vldb  = vldb_pipe_q[RL-1];
    assign douta = da_pipe_q[RL-1];
    assign doutb = db_pipe_q[RL-1];

`ifdef NX_RAM_2RW_WQ_STATS_EN
    logic [STATS_W-1:0] stall_q, stall_d;
    logic [CW-1:0]      hwm_q, hwm_d, level_nxt;

    // Compare against the level being loaded so the mark moves with wq_level.
    always_comb begin
        level_nxt = level + CW'(a_wr) - CW'(drain);
        stall_d   = stall_q;
        if (a_drop && stall_q != '1) stall_d = stall_q + STATS_W'(1);
        hwm_d = (level_nxt > hwm_q) ? level_nxt : hwm_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            hwm_q   <= '0;
        end else begin
            stall_q <= stall_d;
            hwm_q   <= hwm_d;
        end
    end

    assign stall_cnt = stall_q;
    assign wq_hwm    = hwm_q;
`else
    assign stall_cnt = '0;
    assign wq_hwm    = '0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && a_drop)
            $warning("nx_ram_2rw_wq ERROR: port A write to 0x%0h dropped, write queue full", adda);
    end
`endif

endmodule

// File: tb/tb_nx_ram_2rw_wq.sv
// tb_nx_ram_2rw_wq: directed checks of nx_ram_2rw_wq. Two instances share the
// inputs: dut (RD_LATENCY=1) and dut3 (RD_LATENCY=3). 32-bit words, 4 byte lanes.
module tb_nx_ram_2rw_wq;

    localparam int W  = 32;
    localparam int BW = 4;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int WQ = 4;
    localparam int CW = 3;

`ifdef NX_RAM_2RW_WQ_STATS_EN
    localparam logic [31:0]   EXP_STALL = 32'd1;
    localparam logic [CW-1:0] EXP_HWM   = 3'd4;
`else
    localparam logic [31:0]   EXP_STALL = 32'd0;
    localparam logic [CW-1:0] EXP_HWM   = 3'd0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          csa, wea, csb, web;
    logic [AW-1:0] adda, addb;
    logic [W-1:0]  dina, dinb;
    logic [BW-1:0] bwea, bweb;

    logic          rdya, vlda, vldb, rdya3, vlda3, vldb3;
    logic [W-1:0]  douta, doutb, douta3, doutb3;
    logic [CW-1:0] wq_level, wq_hwm, wq_level3, wq_hwm3;
    logic [31:0]   stall_cnt, stall_cnt3;

    int n_chk = 0;
    int n_fail = 0;

    nx_ram_2rw_wq #(.WIDTH(W), .BWEWIDTH(BW), .DEPTH(D), .RD_LATENCY(1),
                    .WQ_DEPTH(WQ), .WRITETHROUGH(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .csa(csa), .wea(wea), .adda(adda), .dina(dina), .bwea(bwea),
        .rdya(rdya), .douta(douta), .vlda(vlda),
        .csb(csb), .web(web), .addb(addb), .dinb(dinb), .bweb(bweb),
        .doutb(doutb), .vldb(vldb),
        .wq_level(wq_level), .stall_cnt(stall_cnt), .wq_hwm(wq_hwm)
    );

    nx_ram_2rw_wq #(.WIDTH(W), .BWEWIDTH(BW), .DEPTH(D), .RD_LATENCY(3),
                    .WQ_DEPTH(WQ), .WRITETHROUGH(1)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .csa(csa), .wea(wea), .adda(adda), .dina(dina), .bwea(bwea),
        .rdya(rdya3), .douta(douta3), .vlda(vlda3),
        .csb(csb), .web(web), .addb(addb), .dinb(dinb), .bweb(bweb),
        .doutb(doutb3), .vldb(vldb3),
        .wq_level(wq_level3), .stall_cnt(stall_cnt3), .wq_hwm(wq_hwm3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csa = 0; wea = 0; adda = '0; dina = '0; bwea = '0;
        csb = 0; web = 0; addb = '0; dinb = '0; bweb = '0;
    endtask

    task automatic a_wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [BW-1:0] l);
        csa = 1; wea = 1; adda = a; dina = d; bwea = l;
    endtask

    task automatic a_rd(input logic [AW-1:0] a);
        csa = 1; wea = 0; adda = a;
    endtask

    task automatic b_wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [BW-1:0] l);
        csb = 1; web = 1; addb = a; dinb = d; bweb = l;
    endtask

    task automatic b_rd(input logic [AW-1:0] a);
        csb = 1; web = 0; addb = a;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (rdya !== 1'b1)      begin n_fail++; $display("FAIL reset_rdya: got %b want 1", rdya); end
        n_chk++; if (wq_level !== 3'd0)  begin n_fail++; $display("FAIL reset_level: got %0d want 0", wq_level); end
        n_chk++; if (vlda !== 1'b0)      begin n_fail++; $display("FAIL reset_vlda: got %b want 0", vlda); end
        n_chk++; if (vldb !== 1'b0)      begin n_fail++; $display("FAIL reset_vldb: got %b want 0", vldb); end
        n_chk++; if (douta !== 32'h0)    begin n_fail++; $display("FAIL reset_douta: got %h want 0", douta); end
        n_chk++; if (doutb !== 32'h0)    begin n_fail++; $display("FAIL reset_doutb: got %h want 0", doutb); end
        n_chk++; if (stall_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        n_chk++; if (wq_hwm !== 3'd0)    begin n_fail++; $display("FAIL reset_hwm: got %0d want 0", wq_hwm); end
        rst_n = 1;
    endtask

    task automatic test_writethrough();
        idle(); a_wr(4'd5, 32'hAAAAAAAA, 4'hF); b_rd(4'd5); step();
        n_chk++; if (vldb !== 1'b1)          begin n_fail++; $display("FAIL wt_vldb: got %b want 1", vldb); end
        n_chk++; if (doutb !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL wt_doutb: got %h want aaaaaaaa", doutb); end
        n_chk++; if (vlda !== 1'b0)          begin n_fail++; $display("FAIL wt_vlda: got %b want 0", vlda); end
        n_chk++; if (wq_level !== 3'd1)      begin n_fail++; $display("FAIL wt_level1: got %0d want 1", wq_level); end
        idle(); step();
        n_chk++; if (vldb !== 1'b0)          begin n_fail++; $display("FAIL wt_vldb_pulse: got %b want 0", vldb); end
        n_chk++; if (doutb !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL wt_doutb_hold: got %h want aaaaaaaa", doutb); end
        n_chk++; if (wq_level !== 3'd0)      begin n_fail++; $display("FAIL wt_drain: got %0d want 0", wq_level); end
        idle(); a_rd(4'd5); step();
        n_chk++; if (vlda !== 1'b1)          begin n_fail++; $display("FAIL wt_vlda_mem: got %b want 1", vlda); end
        n_chk++; if (douta !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL wt_douta_mem: got %h want aaaaaaaa", douta); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            idle(); a_wr(AW'(i), 32'h100 + i, 4'hF); b_wr(4'd4, 32'h44444444, 4'hF); step();
            if (i == 2) begin
                n_chk++; if (rdya !== 1'b1) begin n_fail++; $display("FAIL full_rdya3: got %b want 1", rdya); end
            end
            if (i == 3) begin
                n_chk++; if (rdya !== 1'b0)     begin n_fail++; $display("FAIL full_rdya4: got %b want 0", rdya); end
                n_chk++; if (wq_level !== 3'd4) begin n_fail++; $display("FAIL full_level4: got %0d want 4", wq_level); end
            end
        end
        n_chk++; if (wq_level !== 3'd4)     begin n_fail++; $display("FAIL full_level_drop: got %0d want 4", wq_level); end
        n_chk++; if (stall_cnt !== EXP_STALL) begin n_fail++; $display("FAIL full_stall: got %0d want %0d", stall_cnt, EXP_STALL); end
        n_chk++; if (wq_hwm !== EXP_HWM)    begin n_fail++; $display("FAIL full_hwm: got %0d want %0d", wq_hwm, EXP_HWM); end
        idle(); step();
        n_chk++; if (wq_level !== 3'd3)     begin n_fail++; $display("FAIL full_drain1: got %0d want 3", wq_level); end
        idle(); repeat (3) step();
        n_chk++; if (wq_level !== 3'd0)     begin n_fail++; $display("FAIL full_drain4: got %0d want 0", wq_level); end
        idle(); a_rd(4'd3); b_rd(4'd4); step();
        n_chk++; if (douta !== 32'h103)      begin n_fail++; $display("FAIL full_rd3: got %h want 00000103", douta); end
        n_chk++; if (doutb !== 32'h44444444) begin n_fail++; $display("FAIL full_rd4_dropped: got %h want 44444444", doutb); end
    endtask

    task automatic test_lane_merge();
        idle(); a_wr(4'd3, 32'hA3A2A1A0, 4'hF); b_wr(4'd9, 32'h99999999, 4'hF); step();
        idle(); a_rd(4'd3); b_wr(4'd3, 32'hB3B2B1B0, 4'h3); step();
        n_chk++; if (douta !== 32'hA3A2B1B0) begin n_fail++; $display("FAIL merge_fwd: got %h want a3a2b1b0", douta); end
        n_chk++; if (wq_level !== 3'd1)      begin n_fail++; $display("FAIL merge_level: got %0d want 1", wq_level); end
        idle(); step();
        n_chk++; if (wq_level !== 3'd0)      begin n_fail++; $display("FAIL merge_drain: got %0d want 0", wq_level); end
        idle(); a_rd(4'd3); b_rd(4'd3); step();
        n_chk++; if (douta !== 32'hA3A2B1B0) begin n_fail++; $display("FAIL merge_mem_a: got %h want a3a2b1b0", douta); end
        n_chk++; if (doutb !== 32'hA3A2B1B0) begin n_fail++; $display("FAIL merge_mem_b: got %h want a3a2b1b0", doutb); end
    endtask

    task automatic test_youngest();
        idle(); a_wr(4'd7, 32'h11111111, 4'hF); b_wr(4'd12, 32'hCCCCCCCC, 4'hF); step();
        idle(); a_wr(4'd7, 32'h22222222, 4'h1); b_wr(4'd12, 32'hCCCCCCCC, 4'hF); step();
        idle(); a_rd(4'd7); b_wr(4'd12, 32'hCCCCCCCC, 4'hF); step();
        n_chk++; if (douta !== 32'h11111122) begin n_fail++; $display("FAIL young_fwd_a: got %h want 11111122", douta); end
        n_chk++; if (wq_level !== 3'd2)      begin n_fail++; $display("FAIL young_level: got %0d want 2", wq_level); end
        idle(); b_rd(4'd7); step();
        n_chk++; if (doutb !== 32'h11111122) begin n_fail++; $display("FAIL young_fwd_b: got %h want 11111122", doutb); end
        idle(); step();
        n_chk++; if (wq_level !== 3'd0)      begin n_fail++; $display("FAIL young_drain: got %0d want 0", wq_level); end
        idle(); a_rd(4'd7); step();
        n_chk++; if (douta !== 32'h11111122) begin n_fail++; $display("FAIL young_mem: got %h want 11111122", douta); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] ra [4] = '{4'd3, 4'd7, 4'd0, 4'd1};
        logic [AW-1:0] rb [4] = '{4'd7, 4'd3, 4'd1, 4'd0};
        logic [W-1:0]  ea [4] = '{32'hA3A2B1B0, 32'h11111122, 32'h100, 32'h101};
        logic [W-1:0]  eb [4] = '{32'h11111122, 32'hA3A2B1B0, 32'h101, 32'h100};
        idle(); repeat (3) step();
        for (int c = 0; c < 7; c++) begin
            idle();
            if (c < 4) begin a_rd(ra[c]); b_rd(rb[c]); end
            step();
            n_chk++; if (vlda !== (c < 4)) begin n_fail++; $display("FAIL b2b_vlda c%0d: got %b want %b", c, vlda, c < 4); end
            if (c < 4) begin
                n_chk++; if (douta !== ea[c]) begin n_fail++; $display("FAIL b2b_douta c%0d: got %h want %h", c, douta, ea[c]); end
                n_chk++; if (doutb !== eb[c]) begin n_fail++; $display("FAIL b2b_doutb c%0d: got %h want %h", c, doutb, eb[c]); end
            end
            n_chk++; if (vlda3 !== (c >= 2 && c <= 5)) begin n_fail++; $display("FAIL lat3_vlda c%0d: got %b", c, vlda3); end
            n_chk++; if (vldb3 !== (c >= 2 && c <= 5)) begin n_fail++; $display("FAIL lat3_vldb c%0d: got %b", c, vldb3); end
            if (c >= 2 && c <= 5) begin
                n_chk++; if (douta3 !== ea[c-2]) begin n_fail++; $display("FAIL lat3_douta c%0d: got %h want %h", c, douta3, ea[c-2]); end
                n_chk++; if (doutb3 !== eb[c-2]) begin n_fail++; $display("FAIL lat3_doutb c%0d: got %h want %h", c, doutb3, eb[c-2]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        idle(); a_wr(4'd0, 32'hDEAD0000, 4'hF); b_wr(4'd12, 32'hCCCCCCCC, 4'hF); step();
        idle(); a_wr(4'd1, 32'hDEAD0001, 4'hF); b_wr(4'd12, 32'hCCCCCCCC, 4'hF); step();
        idle(); a_rd(4'd5);                     b_wr(4'd12, 32'hCCCCCCCC, 4'hF); step();
        idle(); a_wr(4'd2, 32'hDEAD0002, 4'hF); b_wr(4'd12, 32'hCCCCCCCC, 4'hF); step();
        n_chk++; if (wq_level !== 3'd3) begin n_fail++; $display("FAIL rmid_level3: got %0d want 3", wq_level); end
        idle();
        rst_n = 0;
        #1;
        n_chk++; if (wq_level !== 3'd0) begin n_fail++; $display("FAIL rmid_level0: got %0d want 0", wq_level); end
        n_chk++; if (rdya !== 1'b1)     begin n_fail++; $display("FAIL rmid_rdya: got %b want 1", rdya); end
        n_chk++; if (vlda !== 1'b0)     begin n_fail++; $display("FAIL rmid_vlda: got %b want 0", vlda); end
        #2;
        rst_n = 1;
        step();
        n_chk++; if (vlda3 !== 1'b0)     begin n_fail++; $display("FAIL rmid_inflight: got %b want 0", vlda3); end
        n_chk++; if (wq_level !== 3'd0)  begin n_fail++; $display("FAIL rmid_nodrain: got %0d want 0", wq_level); end
        n_chk++; if (stall_cnt !== 32'h0) begin n_fail++; $display("FAIL rmid_stall: got %0d want 0", stall_cnt); end
        n_chk++; if (wq_hwm !== 3'd0)    begin n_fail++; $display("FAIL rmid_hwm: got %0d want 0", wq_hwm); end
        idle(); a_rd(4'd0); b_rd(4'd1); step();
        n_chk++; if (douta !== 32'h100) begin n_fail++; $display("FAIL rmid_rd0: got %h want 00000100", douta); end
        n_chk++; if (doutb !== 32'h101) begin n_fail++; $display("FAIL rmid_rd1: got %h want 00000101", doutb); end
        idle(); a_rd(4'd2); step();
        n_chk++; if (douta !== 32'h102) begin n_fail++; $display("FAIL rmid_rd2: got %h want 00000102", douta); end
    endtask

    initial begin
        idle();
        test_reset();
        test_writethrough();
        test_full();
        test_lane_merge();
        test_youngest();
        test_back_to_back();
        test_reset_mid();
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
